// File: rtl/xcvr_ref_clk_monitor.sv
// Reference-clock monitor: synchronises per-channel /2 toggles, counts edges per window,
// qualifies channels and picks an active channel with non-revertive failover and override.
//
// state  | meaning
// NO_REF | no usable channel; SEL_VALID low, ACTIVE_SEL keeps its last value
// LOCKED | ACTIVE_SEL points at a qualified channel; SEL_VALID high
module xcvr_ref_clk_monitor #(
  parameter int NUM_CH     = 2,
  parameter int SEL_W      = 1,
  parameter int WINDOW     = 1024,
  parameter int CNT_W      = 12,
  parameter int MIN_CNT    = 480,
  parameter int MAX_CNT    = 544,
  parameter int OK_WINDOWS = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    en_i,
  input  logic [NUM_CH-1:0]       ref_tog_i,
  input  logic                    force_en_i,
  input  logic [SEL_W-1:0]        force_sel_i,
  output logic [NUM_CH-1:0]       ch_ok_o,
  output logic [SEL_W-1:0]        active_sel_o,
  output logic                    sel_valid_o,
  output logic                    switch_pulse_o,
  output logic [NUM_CH*CNT_W-1:0] last_count_o,
  output logic                    win_done_o
);

  localparam int               WIN_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;
  localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_CNT);
  localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_CNT);
  localparam logic [3:0]       RUN_OK   = 4'(OK_WINDOWS);

  typedef enum logic {NO_REF, LOCKED} sel_state_e;

  logic [NUM_CH-1:0]       sync1_q, sync2_q, sync3_q;
  logic [NUM_CH-1:0]       edge_det;
  logic [WIN_W-1:0]        win_cnt_q;
  logic                    win_term;
  logic [CNT_W-1:0]        edge_cnt_q [NUM_CH];
  logic [CNT_W-1:0]        edge_cnt_d [NUM_CH];
  logic [3:0]              good_run_q [NUM_CH];
  logic [3:0]              good_run_d [NUM_CH];
  logic [NUM_CH-1:0]       win_good;
  logic [NUM_CH-1:0]       ch_ok_q;
  logic [NUM_CH*CNT_W-1:0] last_count_q;
  logic                    win_done_q;
  sel_state_e              state_q;
  logic [SEL_W-1:0]        active_sel_q;
  logic                    sel_valid_q;
  logic                    switch_pulse_q;
  logic [SEL_W-1:0]        lowest_ok;
  logic                    any_ok;
  logic                    active_ok;
  logic                    force_ok;

  // Synchronisers run regardless of EN so the edge detector is clean on re-enable.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
    end else begin
      sync1_q <= ref_tog_i;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign edge_det = sync2_q ^ sync3_q;
  assign win_term = en_i && (win_cnt_q == WIN_LAST);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      win_cnt_q <= '0;
    end else if (!en_i || win_term) begin
      win_cnt_q <= '0;
    end else begin
      win_cnt_q <= win_cnt_q + WIN_W'(1);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      edge_cnt_d[i] = edge_cnt_q[i];
      if (edge_det[i] && (edge_cnt_q[i] != CNT_SAT)) begin
        edge_cnt_d[i] = edge_cnt_q[i] + CNT_W'(1);
      end
      win_good[i]   = (edge_cnt_d[i] >= MIN_C) && (edge_cnt_d[i] <= MAX_C);
      good_run_d[i] = (good_run_q[i] >= RUN_OK) ? RUN_OK : good_run_q[i] + 4'd1;
    end
  end

  // The terminal cycle's own edge is folded into the captured count.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NUM_CH; i++) begin
        edge_cnt_q[i] <= '0;
        good_run_q[i] <= '0;
      end
      ch_ok_q      <= '0;
      last_count_q <= '0;
      win_done_q   <= 1'b0;
    end else begin
      win_done_q <= win_term;
      for (int i = 0; i < NUM_CH; i++) begin
        if (!en_i) begin
          edge_cnt_q[i] <= '0;
          good_run_q[i] <= '0;
          ch_ok_q[i]    <= 1'b0;
        end else if (win_term) begin
          edge_cnt_q[i]                  <= '0;
          last_count_q[i*CNT_W +: CNT_W] <= edge_cnt_d[i];
          if (win_good[i]) begin
            good_run_q[i] <= good_run_d[i];
            ch_ok_q[i]    <= (good_run_d[i] == RUN_OK);
          end else begin
            good_run_q[i] <= '0;
            ch_ok_q[i]    <= 1'b0;
          end
        end else begin
          edge_cnt_q[i] <= edge_cnt_d[i];
        end
      end
    end
  end

  always_comb begin
    lowest_ok = '0;
    active_ok = 1'b0;
    force_ok  = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_ok_q[i]) begin
        lowest_ok = SEL_W'(i);
        if (active_sel_q == SEL_W'(i)) active_ok = 1'b1;
        if (force_sel_i == SEL_W'(i)) force_ok = 1'b1;
      end
    end
  end

  assign any_ok = |ch_ok_q;

  // While forced, the state tracks the forced channel so release resumes correctly.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q        <= NO_REF;
      active_sel_q   <= '0;
      sel_valid_q    <= 1'b0;
      switch_pulse_q <= 1'b0;
    end else if (force_en_i) begin
      active_sel_q   <= force_sel_i;
      sel_valid_q    <= force_ok;
      state_q        <= force_ok ? LOCKED : NO_REF;
      switch_pulse_q <= (force_sel_i != active_sel_q);
    end else if (!en_i) begin
      state_q        <= NO_REF;
      sel_valid_q    <= 1'b0;
      switch_pulse_q <= 1'b0;
    end else begin
      case (state_q)
        NO_REF: begin
          if (any_ok) begin
            state_q        <= LOCKED;
            active_sel_q   <= lowest_ok;
            sel_valid_q    <= 1'b1;
            switch_pulse_q <= (lowest_ok != active_sel_q);
          end else begin
            sel_valid_q    <= 1'b0;
            switch_pulse_q <= 1'b0;
          end
        end
        LOCKED: begin
          if (active_ok) begin
            sel_valid_q    <= 1'b1;
            switch_pulse_q <= 1'b0;
          end else if (any_ok) begin
            active_sel_q   <= lowest_ok;
            sel_valid_q    <= 1'b1;
            switch_pulse_q <= (lowest_ok != active_sel_q);
          end else begin
            state_q        <= NO_REF;
            sel_valid_q    <= 1'b0;
            switch_pulse_q <= 1'b0;
          end
        end
        default: begin
          state_q        <= NO_REF;
          sel_valid_q    <= 1'b0;
          switch_pulse_q <= 1'b0;
        end
      endcase
    end
  end

  assign ch_ok_o        = ch_ok_q;
  assign active_sel_o   = active_sel_q;
  assign sel_valid_o    = sel_valid_q;
  assign switch_pulse_o = switch_pulse_q;
  assign last_count_o   = last_count_q;
  assign win_done_o     = win_done_q;

endmodule

// File: tb/tb_xcvr_ref_clk_monitor.sv
// Bench for xcvr_ref_clk_monitor: per-cycle behavioural model plus directed literal checks.
module tb_xcvr_ref_clk_monitor;

  localparam int NCH  = 2;
  localparam int WIN  = 64;
  localparam int CW   = 8;
  localparam int MINC = 28;
  localparam int MAXC = 36;
  localparam int OKW  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic [1:0]  ref_tog = 2'b00;
  logic        force_en = 1'b0;
  logic [0:0]  force_sel = 1'b0;
  logic [1:0]  ch_ok;
  logic [0:0]  active_sel;
  logic        sel_valid;
  logic        switch_pulse;
  logic [15:0] last_count;
  logic        win_done;

  xcvr_ref_clk_monitor #(
    .NUM_CH(NCH), .SEL_W(1), .WINDOW(WIN), .CNT_W(CW),
    .MIN_CNT(MINC), .MAX_CNT(MAXC), .OK_WINDOWS(OKW)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .ref_tog_i(ref_tog),
    .force_en_i(force_en), .force_sel_i(force_sel),
    .ch_ok_o(ch_ok), .active_sel_o(active_sel), .sel_valid_o(sel_valid),
    .switch_pulse_o(switch_pulse), .last_count_o(last_count), .win_done_o(win_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, got, exp);
    end
  endtask

  // Model: edge counts per window from sampled toggle history, then qualification and selection
  int m_smp [2][3];
  int m_cnt [2];
  int m_run [2];
  int m_ok  [2];
  int m_last[2];
  int m_pos, m_wd, m_sel, m_valid, m_locked, m_pulse;

  always @(posedge clk) begin : model
    int e[2];
    int okold[2];
    int nsel, low, any;
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        for (int k = 0; k < 3; k++) m_smp[i][k] = 0;
        m_cnt[i] = 0; m_run[i] = 0; m_ok[i] = 0; m_last[i] = 0;
      end
      m_pos = 0; m_wd = 0; m_sel = 0; m_valid = 0; m_locked = 0; m_pulse = 0;
    end else begin
      okold = m_ok;
      any = 0; low = 0;
      for (int i = 1; i >= 0; i--) if (okold[i] != 0) begin any = 1; low = i; end
      nsel = m_sel;
      if (force_en) begin
        nsel = int'(force_sel);
        m_valid = (int'(force_sel) < NCH && okold[force_sel] != 0) ? 1 : 0;
        m_locked = m_valid;
      end else if (!en) begin
        m_locked = 0; m_valid = 0;
      end else if (m_locked != 0 && okold[m_sel] != 0) begin
        m_valid = 1;
      end else if (any != 0) begin
        nsel = low; m_locked = 1; m_valid = 1;
      end else begin
        m_locked = 0; m_valid = 0;
      end
      m_pulse = (nsel != m_sel) ? 1 : 0;
      m_sel = nsel;
      for (int i = 0; i < 2; i++) begin
        e[i] = (m_smp[i][1] != m_smp[i][2]) ? 1 : 0;
        m_smp[i][2] = m_smp[i][1];
        m_smp[i][1] = m_smp[i][0];
        m_smp[i][0] = int'(ref_tog[i]);
      end
      if (!en) begin
        m_pos = 0; m_wd = 0;
        for (int i = 0; i < 2; i++) begin m_cnt[i] = 0; m_run[i] = 0; m_ok[i] = 0; end
      end else begin
        for (int i = 0; i < 2; i++) m_cnt[i] = (m_cnt[i] + e[i] > 255) ? 255 : m_cnt[i] + e[i];
        if (m_pos == WIN - 1) begin
          m_wd = 1; m_pos = 0;
          for (int i = 0; i < 2; i++) begin
            m_last[i] = m_cnt[i];
            if (m_cnt[i] >= MINC && m_cnt[i] <= MAXC) begin
              m_run[i] = (m_run[i] + 1 > OKW) ? OKW : m_run[i] + 1;
              m_ok[i] = (m_run[i] == OKW) ? 1 : 0;
            end else begin
              m_run[i] = 0; m_ok[i] = 0;
            end
            m_cnt[i] = 0;
          end
        end else begin
          m_wd = 0; m_pos++;
        end
      end
    end
  end

  always @(posedge clk) begin : compare
    #1;
    check("ch_ok", 32'(ch_ok), 32'(m_ok[1] * 2 + m_ok[0]));
    check("active_sel", 32'(active_sel), 32'(m_sel));
    check("sel_valid", 32'(sel_valid), 32'(m_valid));
    check("switch_pulse", 32'(switch_pulse), 32'(m_pulse));
    check("last_count", 32'(last_count), 32'(m_last[1] * 256 + m_last[0]));
    check("win_done", 32'(win_done), 32'(m_wd));
  end

  // Each channel toggles rate[ch] times per 64 cycles, evenly spread, so any 64-cycle span holds exactly that many
  int rate[2] = '{0, 0};
  int gc = 0;

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      gc++;
      for (int ch = 0; ch < 2; ch++) begin
        if (rate[ch] > 0 && ((gc * rate[ch]) % 64) < rate[ch]) ref_tog[ch] = !ref_tog[ch];
      end
    end
  endtask

  task automatic wait_wd();
    int n;
    n = 0;
    do begin
      step(1);
      n++;
    end while (!win_done && n < 200);
    if (!win_done) begin
      total++; bad++;
      $display("FAIL wait_win_done timeout t=%0t got=0 exp=1", $time);
    end
  endtask

  int bnd[4] = '{27, 28, 36, 37};
  int bok[4] = '{0, 1, 1, 0};

  initial begin
    step(3);
    check("rst_outputs", 32'({ch_ok, active_sel, sel_valid, switch_pulse, win_done}), 32'd0);
    check("rst_last_count", 32'(last_count), 32'd0);
    rst_n = 1'b1;
    rate[0] = 32;

    wait_wd();
    check("w1_ch0_in_31_33", 32'((last_count[7:0] >= 8'd31) && (last_count[7:0] <= 8'd33)), 32'd1);
    check("w1_ch1_cnt", 32'(last_count[15:8]), 32'd0);
    check("w1_ch_ok", 32'(ch_ok), 32'd0);
    wait_wd();
    check("w2_ch0_cnt", 32'(last_count[7:0]), 32'd32);
    check("w2_ch_ok", 32'(ch_ok), 32'd1);
    step(1);
    check("lock_sel", 32'(active_sel), 32'd0);
    check("lock_valid", 32'(sel_valid), 32'd1);
    check("lock_no_pulse", 32'(switch_pulse), 32'd0);

    rate[1] = 32;
    repeat (3) wait_wd();
    check("both_ok", 32'(ch_ok), 32'd3);
    check("both_sel", 32'(active_sel), 32'd0);
    rate[0] = 0;
    wait_wd();
    check("ch0_drop_ok", 32'(ch_ok), 32'd2);
    step(1);
    check("failover_sel", 32'(active_sel), 32'd1);
    check("failover_pulse", 32'(switch_pulse), 32'd1);
    check("failover_valid", 32'(sel_valid), 32'd1);
    rate[0] = 32;
    repeat (3) wait_wd();
    step(1);
    check("recover_ok", 32'(ch_ok), 32'd3);
    check("nonrevert_sel", 32'(active_sel), 32'd1);

    rate[0] = 64;
    repeat (2) wait_wd();
    check("fast_ch0_cnt", 32'(last_count[7:0]), 32'd64);
    check("fast_ch_ok", 32'(ch_ok), 32'd2);
    rate[1] = 0;
    wait_wd();
    check("none_ok", 32'(ch_ok), 32'd0);
    step(1);
    check("none_valid", 32'(sel_valid), 32'd0);
    check("none_sel_held", 32'(active_sel), 32'd1);

    rate[1] = 32;
    for (int b = 0; b < 4; b++) begin
      rate[0] = bnd[b];
      repeat (3) wait_wd();
      check("bound_cnt", 32'(last_count[7:0]), 32'(bnd[b]));
      check("bound_ok", 32'(ch_ok[0]), 32'(bok[b]));
    end

    rate[0] = 32;
    rate[1] = 0;
    repeat (3) wait_wd();
    step(1);
    check("pre_force_ok", 32'(ch_ok), 32'd1);
    check("pre_force_sel", 32'(active_sel), 32'd0);
    force_sel = 1'b1;
    force_en = 1'b1;
    step(1);
    check("force_sel", 32'(active_sel), 32'd1);
    check("force_pulse", 32'(switch_pulse), 32'd1);
    check("force_valid", 32'(sel_valid), 32'd0);
    step(4);
    force_en = 1'b0;
    step(1);
    check("release_sel", 32'(active_sel), 32'd0);
    check("release_pulse", 32'(switch_pulse), 32'd1);
    check("release_valid", 32'(sel_valid), 32'd1);

    step(20);
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", 32'({ch_ok, active_sel, sel_valid, switch_pulse, win_done}), 32'd0);
    check("midrst_last", 32'(last_count), 32'd0);
    step(3);
    rst_n = 1'b1;
    wait_wd();
    check("rq1_ok", 32'(ch_ok), 32'd0);
    wait_wd();
    check("rq2_ok", 32'(ch_ok), 32'd1);

    step(20);
    en = 1'b0;
    step(5);
    check("endrop_ok", 32'(ch_ok), 32'd0);
    check("endrop_last_held", 32'(last_count[7:0]), 32'd32);
    check("endrop_valid", 32'(sel_valid), 32'd0);
    en = 1'b1;
    wait_wd();
    check("reen1_ok", 32'(ch_ok), 32'd0);
    wait_wd();
    check("reen2_ok", 32'(ch_ok), 32'd1);
    step(1);
    check("reen_valid", 32'(sel_valid), 32'd1);
    check("reen_sel", 32'(active_sel), 32'd0);

    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xcvr_ref_clk_monitor.md
Name: xcvr_ref_clk_monitor

Overview:
- Parametrised multi-channel monitor and selector for transceiver reference clocks.
- Each channel supplies a divided-by-2 toggle generated in its own ref-clock domain. The block synchronises each toggle into CLK, counts edges over a fixed CLK window and qualifies each channel as in-range.
- It chooses one active channel with non-revertive failover, plus a software override.
- Sits between the XCVR_REF_CLK wrappers and the PCIe/XCVR PLL reset/select logic.

Parameters:
- NUM_CH, 2, number of monitored ref-clock channels (1..8)
- SEL_W, 1, width of channel index; must equal max(1,clog2(NUM_CH))
- WINDOW, 1024, measurement window length in CLK cycles (>=16)
- CNT_W, 12, per-channel edge-counter width; counter saturates at 2^CNT_W-1
- MIN_CNT, 480, minimum edges per window for a good window
- MAX_CNT, 544, maximum edges per window for a good window
- OK_WINDOWS, 4, consecutive good windows required to declare a channel OK (1..15)

Ports:
- CLK  in  1  system/monitor clock
- RESETN  in  1  asynchronous active-low reset
- EN  in  1  monitor enable
- REF_TOG  in  NUM_CH  per-channel toggle from ref-clock domain (asynchronous)
- FORCE_EN  in  1  override automatic selection
- FORCE_SEL  in  SEL_W  channel used when FORCE_EN=1
- CH_OK  out  NUM_CH  per-channel qualified status
- ACTIVE_SEL  out  SEL_W  selected channel index
- SEL_VALID  out  1  selected channel is OK
- SWITCH_PULSE  out  1  one-cycle pulse on any ACTIVE_SEL change
- LAST_COUNT  out  NUM_CH*CNT_W  edge count of last completed window; channel i at [i*CNT_W +: CNT_W]
- WIN_DONE  out  1  one-cycle pulse when LAST_COUNT/CH_OK update

Behaviour:
- Reset (async assert, sync release) clears all outputs and state: CH_OK=0, ACTIVE_SEL=0, SEL_VALID=0, SWITCH_PULSE=0, LAST_COUNT=0, WIN_DONE=0, all counters 0, FSM=NO_REF.
- Sync: 2-FF synchroniser per REF_TOG bit, plus a third flop for edge detect. An edge is any change between flop2 and flop3, so the count equals the ref-clock cycles / 2 pulses. Latency from REF_TOG change to count increment is 3 CLK.
- Window counter runs 0..WINDOW-1 while EN=1. At count WINDOW-1 (the terminal cycle), each channel's count, including any edge in that cycle, goes to LAST_COUNT. WIN_DONE pulses the next cycle, together with the CH_OK update. Channel counters restart at 0 on the cycle after terminal.
- Edge counters saturate at 2^CNT_W-1; a saturated count is treated as bad if it exceeds MAX_CNT.
- Good window: MIN_CNT <= count <= MAX_CNT, bounds inclusive.
  - On a good window, good_run increments, saturating at OK_WINDOWS. CH_OK sets when good_run reaches OK_WINDOWS.
  - On a bad window, good_run=0 and CH_OK clears at that window's update (fast drop, slow qualify).
- EN=0: window and edge counters held at 0, good_run=0, CH_OK=0, LAST_COUNT held, FSM -> NO_REF. The synchronisers keep running.
- Selection FSM, evaluated on the cycle after the CH_OK update:
  - NO_REF: SEL_VALID=0. If any CH_OK, ACTIVE_SEL <= lowest-index OK channel, go to LOCKED.
  - LOCKED: SEL_VALID=1. Non-revertive: a lower-index channel becoming OK causes no switch. If CH_OK[ACTIVE_SEL] drops, move to the lowest-index other OK channel and stay in LOCKED. If no channel is OK, go to NO_REF and keep ACTIVE_SEL unchanged.
  - FORCE_EN=1 bypasses the FSM: ACTIVE_SEL=FORCE_SEL registered (1-cycle latency) and SEL_VALID=CH_OK[FORCE_SEL]. FORCE_SEL >= NUM_CH gives SEL_VALID=0.
  - When FORCE_EN falls, the FSM resumes from LOCKED on the forced channel if it is OK, else from NO_REF.
- SWITCH_PULSE is high for exactly one cycle on the cycle after any ACTIVE_SEL register change, whether automatic or forced. It is not asserted when ACTIVE_SEL stays unchanged through NO_REF.
- Async reset mid-window discards the partial count. No WIN_DONE is issued for the aborted window.

Test Plan (NUM_CH=2, WINDOW=64, MIN_CNT=28, MAX_CNT=36, OK_WINDOWS=2, CNT_W=8):
- Reset release with REF_TOG[0] toggling every 2 CLK and ch1 static:
  - LAST_COUNT ch0 = 32 (±1 in the first window only), ch1 = 0.
  - CH_OK=01 after the 2nd WIN_DONE; ACTIVE_SEL=0, SEL_VALID=1, no SWITCH_PULSE.
- Both channels good, then ch0 stops toggling:
  - At the next WIN_DONE, CH_OK=10 and ACTIVE_SEL moves to 1 with SWITCH_PULSE for 1 cycle.
  - ch0 recovering for 2 windows gives CH_OK=11 with ACTIVE_SEL still 1 (non-revertive).
- ch0 toggling every CLK (64 edges > 36): CH_OK[0] never sets; LAST_COUNT=64. Both channels bad gives SEL_VALID=0 and FSM NO_REF.
- Boundary counts 27, 28, 36, 37 edges per window (toggle gaps arranged accordingly): only 28 and 36 count as good.
- FORCE_EN=1 with FORCE_SEL=1 while locked on 0 and ch1 bad: ACTIVE_SEL=1 one cycle later, SWITCH_PULSE, SEL_VALID=0. Releasing FORCE_EN returns to channel 0 via the FSM.
- Mid-window, assert RESETN low for 3 cycles or drop EN:
  - All outputs go to reset values (EN drop: counters and CH_OK cleared, LAST_COUNT held).
  - Requalification needs 2 full windows after release.
